inst_fetch_unit: RTL and testbench

//  Producer side of the instruction stream consumed by the decoder. Generates sequential PCs,

---
 rtl/inst_fetch_unit_pkg.sv | 19 +
 rtl/inst_fetch_unit_if.sv | 30 +++
 rtl/inst_fetch_unit_fetch_queue.sv | 73 +++++++
 rtl/inst_fetch_unit.sv | 122 ++++++++++++
 tb/tb_inst_fetch_unit.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared widths, fetch FSM encoding and the buffered-instruction payload.
package inst_fetch_unit_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_DATA_W = 32;
    localparam logic [INST_ADDR_W-1:0] PC_STEP = INST_ADDR_W'(4);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INST_DATA_W-1:0] inst;
        logic [INST_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bus bundle: imem request/response, redirect, and decode-side stream.
//  master: the fetch unit; slave: memory + decoder side.
interface inst_fetch_unit_if;
    import inst_fetch_unit_pkg::*;

    logic                   imem_req_valid;
    logic [INST_ADDR_W-1:0] imem_req_addr;
    logic                   imem_req_ready;
    logic                   imem_resp_valid;
    logic [INST_DATA_W-1:0] imem_resp_data;
    logic                   redirect_valid;
    logic [INST_ADDR_W-1:0] redirect_pc;
    logic                   inst_valid;
    logic [INST_DATA_W-1:0] inst;
    logic [INST_ADDR_W-1:0] inst_pc;
    logic                   inst_ready;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, inst_ready
    );

endinterface

// File: rtl/inst_fetch_unit_fetch_queue.sv
// Synchronous FIFO, DEPTH x WIDTH, with flush; head is read straight from flops.
//  clk/rst   : clock, synchronous active-high reset
//  push/push_data, pop, flush : write, consume head, clear (flush wins)
//  head      : current head entry (valid when !empty)
//  empty/count : status, count ranges 0..DEPTH
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full, push_ok, pop_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Push into a full queue is accepted only when the head leaves the same cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: sequential PC generation, credit-limited imem reads,
// DEPTH-entry instruction queue to decode, redirect flush with stale-response drop.
//  clk, rst : clock, synchronous active-high reset
//  bus      : master side of inst_fetch_unit_if (imem req/resp, redirect, inst stream)
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int unsigned           DEPTH    = 4,
    parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    inst_fetch_unit_if.master  bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_t           state_q, state_d;
    logic [INST_ADDR_W-1:0] pc_q, pc_d;
    logic [CW-1:0]          outstanding_q, outstanding_d;
    logic [CW-1:0]          drop_q, drop_d;
    logic [CW-1:0]          occupancy, tag_count;
    logic [CW:0]            in_use;
    logic                   req_valid_c, req_fire, resp_fire, resp_keep, pop_fire;
    logic                   data_empty, tag_empty;
    logic [INST_ADDR_W-1:0] tag_head;
    fetch_entry_t           push_entry, head_entry;

    // In FETCH the tag FIFO holds exactly the outstanding requests, so it serves as the credit count.
    assign in_use      = {1'b0, occupancy} + {1'b0, tag_count};
    assign req_valid_c = (state_q == ST_FETCH) && (in_use < (CW+1)'(DEPTH)) && !bus.redirect_valid;
    assign req_fire    = req_valid_c & bus.imem_req_ready;
    assign resp_fire   = bus.imem_resp_valid;
    assign resp_keep   = resp_fire & (state_q == ST_FETCH) & ~bus.redirect_valid;
    assign pop_fire    = ~data_empty & bus.inst_ready;
    assign push_entry  = {bus.imem_resp_data, tag_head};

    assign bus.imem_req_valid = req_valid_c;
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = ~data_empty;
    assign bus.inst           = head_entry.inst;
    assign bus.inst_pc        = head_entry.pc;

    // Next-state: redirect overrides everything and re-arms the drop counter.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (req_fire) begin
                    pc_d = pc_q + PC_STEP;
                end
                outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_fire);
            end
            ST_FLUSH: begin
                if (drop_q == '0) begin
                    state_d = ST_FETCH;
                end else if (resp_fire) begin
                    drop_d        = drop_q - CW'(1);
                    outstanding_d = outstanding_q - CW'(1);
                    if (drop_q == CW'(1)) begin
                        state_d = ST_FETCH;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (bus.redirect_valid) begin
            pc_d          = bus.redirect_pc & ~INST_ADDR_W'(3);
            drop_d        = outstanding_q + CW'(req_fire) - CW'(resp_fire);
            outstanding_d = drop_d;
            state_d       = (drop_d != '0) ? ST_FLUSH : ST_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    // Instruction queue toward decode.
    fetch_queue #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_inst_q (
        .clk       (clk),
        .rst       (rst),
        .push      (resp_keep),
        .push_data (push_entry),
        .pop       (pop_fire),
        .flush     (bus.redirect_valid),
        .head      (head_entry),
        .empty     (data_empty),
        .count     (occupancy)
    );

    // Issue-PC tags, paired in order with returning responses.
    fetch_queue #(.DEPTH(DEPTH), .WIDTH(INST_ADDR_W)) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (resp_keep & ~tag_empty),
        .flush     (bus.redirect_valid),
        .head      (tag_head),
        .empty     (tag_empty),
        .count     (tag_count)
    );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: latency-programmable memory model, scoreboard on the inst stream.
module tb_inst_fetch_unit;
    import inst_fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_fetch_unit_if bus ();

    inst_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          due;
        logic [31:0] addr;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          lat      = 1;
    pend_t       pend_q[$];
    logic [31:0] acc_addr[$];
    int          acc_edge[$];
    int          deliv_edge[$];
    exp_t        exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_seq(input logic [31:0] base, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.pc   = base + 32'(4 * i);
            e.inst = mem_word(e.pc);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_accepts(input int n, input int budget);
        int k = 0;
        while (acc_addr.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (acc_addr.size() < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got %0d accepts required %0d", acc_addr.size(), n);
        end
    endtask

    task automatic wait_delivered(input int n, input int budget);
        int k = 0;
        while (deliv_edge.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (deliv_edge.size() < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL deliver_timeout: got %0d instructions required %0d", deliv_edge.size(), n);
        end
    endtask

    task automatic clear_logs();
        exp_q.delete();
        acc_addr.delete();
        acc_edge.delete();
        deliv_edge.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        repeat (3) tick();
        clear_logs();
        rst = 1'b0;
    endtask

    // Memory model: in-order responses, lat cycles after acceptance; cleared by rst.
    initial begin
        pend_t p;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_q.delete();
            end else if (bus.imem_req_valid && bus.imem_req_ready) begin
                p.due  = cyc + lat;
                p.addr = bus.imem_req_addr;
                pend_q.push_back(p);
                acc_addr.push_back(bus.imem_req_addr);
                acc_edge.push_back(cyc + 1);
            end
            @(posedge clk);
            #2;
            if (!rst && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = mem_word(pend_q[0].addr);
                void'(pend_q.pop_front());
            end else begin
                bus.imem_resp_valid = 1'b0;
                bus.imem_resp_data  = '0;
            end
        end
    end

    // Scoreboard monitor: every handshake on the inst stream pops one expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.inst_valid && bus.inst_ready) begin
                deliv_edge.push_back(cyc + 1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_inst: got pc %h inst %h, expected none", bus.inst_pc, bus.inst);
                end else begin
                    e = exp_q.pop_front();
                    check("inst_stream", {bus.inst_pc, bus.inst}, {e.pc, e.inst});
                end
            end
        end
    end

    initial begin
        #60000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int r_edge;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        // Reset state and first request timing.
        repeat (2) tick();
        @(negedge clk);
        check("rst_req_valid", 64'(bus.imem_req_valid), 64'(0));
        check("rst_inst_valid", 64'(bus.inst_valid), 64'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_req", 64'(bus.imem_req_valid), 64'(0));
        @(negedge clk);
        check("first_req_valid", 64'(bus.imem_req_valid), 64'(1));
        check("first_req_addr", 64'(bus.imem_req_addr), 64'(32'h0));

        // Streaming with latency 1.
        lat = 1;
        bus.inst_ready = 1'b1;
        do_reset();
        expect_seq(32'h0, 12);
        wait_delivered(12, 60);
        bus.inst_ready = 1'b0;
        check("t1_drain", 64'(exp_q.size()), 64'(0));
        for (int i = 0; i < 12; i++) begin
            check("t1_issue_addr", 64'(acc_addr[i]), 64'(32'(4 * i)));
        end
        check("t1_first_latency", 64'(deliv_edge[0] - acc_edge[0]), 64'(2));
        check("t1_throughput", 64'(deliv_edge[11] - deliv_edge[4]), 64'(7));

        // Decode stalled: credit limits fetch to DEPTH, head held.
        lat = 1;
        bus.inst_ready = 1'b0;
        do_reset();
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.inst_valid && bus.inst_pc !== 32'h0) bad++;
        end
        check("t2_head_stable", 64'(bad), 64'(0));
        check("t2_inst_valid_held", 64'(bus.inst_valid), 64'(1));
        check("t2_req_count", 64'(acc_addr.size()), 64'(4));
        check("t2_req_blocked", 64'(bus.imem_req_valid), 64'(0));
        tick();
        expect_seq(32'h0, 8);
        bus.inst_ready = 1'b1;
        wait_delivered(8, 60);
        bus.inst_ready = 1'b0;
        check("t2_drain", 64'(exp_q.size()), 64'(0));
        check("t2_resume_addr", 64'(acc_addr[4]), 64'(32'h10));

        // Redirect with 3 in flight (latency 3), unaligned target.
        lat = 3;
        bus.inst_ready = 1'b1;
        do_reset();
        wait_accepts(3, 20);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0402;
        r_edge = cyc + 1;
        expect_seq(32'h400, 8);
        tick();
        bus.redirect_valid = 1'b0;
        wait_delivered(8, 80);
        bus.inst_ready = 1'b0;
        check("t3_drain", 64'(exp_q.size()), 64'(0));
        check("t3_redirect_addr", 64'(acc_addr[3]), 64'(32'h400));
        check("t3_refetch_delay", 64'(acc_edge[3] - r_edge), 64'(3));

        // Second redirect while flushing.
        lat = 3;
        bus.inst_ready = 1'b1;
        do_reset();
        wait_accepts(3, 20);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0400;
        tick();
        bus.redirect_pc    = 32'h0000_0800;
        expect_seq(32'h800, 8);
        tick();
        bus.redirect_valid = 1'b0;
        wait_delivered(8, 80);
        bus.inst_ready = 1'b0;
        check("t4_drain", 64'(exp_q.size()), 64'(0));
        check("t4_redirect_addr", 64'(acc_addr[3]), 64'(32'h800));

        // Memory back-pressure, then PC wrap.
        lat = 1;
        bus.inst_ready = 1'b0;
        do_reset();
        wait_accepts(2, 20);
        bus.imem_req_ready = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (!(bus.imem_req_valid === 1'b1 && bus.imem_req_addr === 32'h8)) bad++;
        end
        check("t5_addr_stable", 64'(bad), 64'(0));
        check("t5_no_accept", 64'(acc_addr.size()), 64'(2));
        tick();
        bus.imem_req_ready = 1'b1;
        wait_accepts(4, 20);
        check("t5_addr_after_stall", 64'(acc_addr[2]), 64'(32'h8));
        repeat (3) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFF8;
        tick();
        bus.redirect_valid = 1'b0;
        expect_seq(32'hFFFF_FFF8, 6);
        bus.inst_ready = 1'b1;
        wait_delivered(6, 60);
        bus.inst_ready = 1'b0;
        check("t5_drain", 64'(exp_q.size()), 64'(0));
        check("t5_wrap_addr0", 64'(acc_addr[4]), 64'(32'hFFFF_FFF8));
        check("t5_wrap_addr1", 64'(acc_addr[5]), 64'(32'hFFFF_FFFC));
        check("t5_wrap_addr2", 64'(acc_addr[6]), 64'(32'h0));

        // Reset mid-operation with requests in flight and entries queued.
        lat = 3;
        bus.inst_ready = 1'b0;
        do_reset();
        wait_accepts(4, 20);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("t6_queued_before_rst", 64'(bus.inst_valid), 64'(1));
        tick();
        clear_logs();
        rst = 1'b0;
        expect_seq(32'h0, 4);
        bus.inst_ready = 1'b1;
        @(negedge clk);
        check("t6_inst_valid_after_rst", 64'(bus.inst_valid), 64'(0));
        check("t6_req_valid_after_rst", 64'(bus.imem_req_valid), 64'(0));
        wait_delivered(4, 40);
        bus.inst_ready = 1'b0;
        check("t6_drain", 64'(exp_q.size()), 64'(0));
        check("t6_refetch_addr", 64'(acc_addr[0]), 64'(32'h0));

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
